// File: rtl/lock_code_writer.sv
// Programming side of the coded lock: a two-entry confirm sequence on the
// switches and debounced key replaces the 4-bit code fed to the lock comparator.
module lock_code_writer #(
  parameter logic [3:0]  DEFAULT_CODE   = 4'b0101,
  parameter int unsigned TIMEOUT_CYCLES = 60000000,
  parameter int unsigned HOLD_CYCLES    = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       key_pulse,
  input  logic       prog_en,
  input  logic       unlocked,
  output logic [3:0] code,
  output logic       busy,
  output logic       led_prog,
  output logic       led_err,
  output logic [8:0] seg_led
);

  localparam int unsigned T_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] T_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD_LAST    = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER1,
    S_ENTER2,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    first;
  logic [TW-1:0] timer;
  logic          capture;

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (key_pulse && prog_en && unlocked) state_nx = S_ENTER1;
      end
      // Abort outranks a key pulse; a key pulse outranks the timeout.
      S_ENTER1: begin
        if (!prog_en || !unlocked) begin
          state_nx = S_IDLE;
        end else if (key_pulse) begin
          if (sw == 4'b0000) begin
            state_nx = S_ERROR;
          end else begin
            capture  = 1'b1;
            state_nx = S_ENTER2;
          end
        end else if (timer == T_TIMEOUT_LAST) begin
          state_nx = S_ERROR;
        end
      end
      S_ENTER2: begin
        if (!prog_en || !unlocked) begin
          state_nx = S_IDLE;
        end else if (key_pulse) begin
          state_nx = (sw == first) ? S_COMMIT : S_ERROR;
        end else if (timer == T_TIMEOUT_LAST) begin
          state_nx = S_ERROR;
        end
      end
      S_COMMIT: state_nx = S_DONE;
      S_DONE, S_ERROR: begin
        if (timer == T_HOLD_LAST) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Every accepted key pulse changes state, so clearing on a state change
  // also covers the restart-on-pulse case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      first <= '0;
      timer <= '0;
      code  <= DEFAULT_CODE;
    end else begin
      state <= state_nx;
      if (capture) first <= sw;
      if (state == S_COMMIT) code <= first;
      if (state_nx != state) begin
        timer <= '0;
      end else if (state != S_IDLE && timer != '1) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    led_prog = !(state == S_ENTER1 || state == S_ENTER2);
    led_err  = (state != S_ERROR);
    unique case (state)
      S_IDLE:           seg_led = 9'h03f;
      S_ENTER1:         seg_led = 9'h006;
      S_ENTER2:         seg_led = 9'h05b;
      S_COMMIT, S_DONE: seg_led = 9'h05e;
      S_ERROR:          seg_led = 9'h079;
      default:          seg_led = 9'h03f;
    endcase
  end

endmodule

// File: tb/tb_lock_code_writer.sv
// Scoreboard bench for lock_code_writer: stimulus queues the expected outputs
// for each cycle, a negedge monitor pops and compares them.
module tb_lock_code_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic       key_pulse = 1'b0;
  logic       prog_en = 1'b0;
  logic       unlocked = 1'b0;
  logic [3:0] code;
  logic       busy;
  logic       led_prog;
  logic       led_err;
  logic [8:0] seg_led;

  lock_code_writer #(
    .DEFAULT_CODE  (4'b0101),
    .TIMEOUT_CYCLES(20),
    .HOLD_CYCLES   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .key_pulse(key_pulse),
    .prog_en  (prog_en),
    .unlocked (unlocked),
    .code     (code),
    .busy     (busy),
    .led_prog (led_prog),
    .led_err  (led_err),
    .seg_led  (seg_led)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_ENTER1, M_ENTER2, M_DONE, M_ERROR} mstate_t;

  typedef struct {
    string      name;
    logic [3:0] code;
    logic       busy;
    logic       led_prog;
    logic       led_err;
    logic [8:0] seg;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t exp_of(input string name, input mstate_t st, input logic [3:0] c);
    exp_t e;
    e.name = name;
    e.code = c;
    case (st)
      M_IDLE:   begin e.busy = 0; e.led_prog = 1; e.led_err = 1; e.seg = 9'h03f; end
      M_ENTER1: begin e.busy = 1; e.led_prog = 0; e.led_err = 1; e.seg = 9'h006; end
      M_ENTER2: begin e.busy = 1; e.led_prog = 0; e.led_err = 1; e.seg = 9'h05b; end
      M_DONE:   begin e.busy = 1; e.led_prog = 1; e.led_err = 1; e.seg = 9'h05e; end
      default:  begin e.busy = 1; e.led_prog = 1; e.led_err = 0; e.seg = 9'h079; end
    endcase
    return e;
  endfunction

  task automatic expect_st(input string name, input mstate_t st, input logic [3:0] c);
    q.push_back(exp_of(name, st, c));
  endtask

  task automatic check_now(input string name, input mstate_t st, input logic [3:0] c);
    exp_t e;
    e = exp_of(name, st, c);
    checks++;
    if ({code, busy, led_prog, led_err, seg_led} !==
        {e.code, e.busy, e.led_prog, e.led_err, e.seg}) begin
      failures++;
      $display("FAIL %s (immediate): got code=%b busy=%b led_prog=%b led_err=%b seg=%h, want code=%b busy=%b led_prog=%b led_err=%b seg=%h",
               name, code, busy, led_prog, led_err, seg_led,
               e.code, e.busy, e.led_prog, e.led_err, e.seg);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({code, busy, led_prog, led_err, seg_led} !==
          {e.code, e.busy, e.led_prog, e.led_err, e.seg}) begin
        failures++;
        $display("FAIL %s: got code=%b busy=%b led_prog=%b led_err=%b seg=%h, want code=%b busy=%b led_prog=%b led_err=%b seg=%h",
                 e.name, code, busy, led_prog, led_err, seg_led,
                 e.code, e.busy, e.led_prog, e.led_err, e.seg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] s);
    sw = s;
    key_pulse = 1'b1;
    tick();
    key_pulse = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_now("reset_state", M_IDLE, 4'b0101);
    expect_st("reset", M_IDLE, 4'b0101);
    tick();
    expect_st("idle_quiet", M_IDLE, 4'b0101);

    unlocked = 1'b1;
    prog_en  = 1'b1;
    pulse(4'b0000);
    expect_st("enter1", M_ENTER1, 4'b0101);
    pulse(4'b1010);
    expect_st("enter2", M_ENTER2, 4'b0101);
    pulse(4'b1010);
    expect_st("commit", M_DONE, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      key_pulse = (i == 2);
      tick();
      expect_st("done_hold", M_DONE, 4'b1010);
    end
    key_pulse = 1'b0;
    tick();
    expect_st("done_to_idle", M_IDLE, 4'b1010);

    pulse(4'b0000);
    pulse(4'b1010);
    expect_st("mm_enter2", M_ENTER2, 4'b1010);
    pulse(4'b1011);
    expect_st("mm_error", M_ERROR, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_st("err_hold", M_ERROR, 4'b1010);
    end
    tick();
    expect_st("err_to_idle", M_IDLE, 4'b1010);

    pulse(4'b0000);
    pulse(4'b0000);
    expect_st("reserved_err", M_ERROR, 4'b1010);
    repeat (5) tick();
    expect_st("reserved_idle", M_IDLE, 4'b1010);

    pulse(4'b0000);
    pulse(4'b0110);
    expect_st("abort_enter2", M_ENTER2, 4'b1010);
    unlocked = 1'b0;
    pulse(4'b0110);
    expect_st("abort_idle", M_IDLE, 4'b1010);

    pulse(4'b0000);
    expect_st("locked_key", M_IDLE, 4'b1010);
    unlocked = 1'b1;

    pulse(4'b0000);
    for (int i = 1; i <= 19; i++) begin
      tick();
      expect_st("to_wait", M_ENTER1, 4'b1010);
    end
    tick();
    check_now("timeout_expired", M_ERROR, 4'b1010);
    expect_st("timeout", M_ERROR, 4'b1010);
    repeat (5) tick();
    expect_st("to_idle", M_IDLE, 4'b1010);

    pulse(4'b0000);
    repeat (19) tick();
    expect_st("last_cycle", M_ENTER1, 4'b1010);
    pulse(4'b0011);
    expect_st("late_pulse", M_ENTER2, 4'b1010);
    for (int i = 1; i <= 19; i++) begin
      tick();
      expect_st("restart_wait", M_ENTER2, 4'b1010);
    end
    tick();
    expect_st("timeout2", M_ERROR, 4'b1010);
    repeat (5) tick();

    pulse(4'b0000);
    pulse(4'b1100);
    pulse(4'b1100);
    tick();
    expect_st("commit_1100", M_DONE, 4'b1100);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_now("async_rst_now", M_IDLE, 4'b0101);
    expect_st("async_rst", M_IDLE, 4'b0101);
    tick();
    rst = 1'b0;
    expect_st("post_rst", M_IDLE, 4'b0101);
    tick();
    expect_st("post_rst_idle", M_IDLE, 4'b0101);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
